dtree_feature_loader: RTL

DTREE_FEATURE_LOADER -- requirements
Module: dtree_feature_loader

---
 rtl/dtree_feature_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/dtree_feature_loader.sv
// Feature loader for a combinational decision tree: gathers NFEAT bytes,
// lets the tree settle, then holds the registered class until taken.
`timescale 1ns/1ps
module dtree_feature_loader #(
   parameter int NFEAT  = 16,
   parameter int FW     = 8,
   parameter int CW     = 4,
   parameter int SETTLE = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [FW-1:0]       s_data,
   input  logic                flush,
   output logic [NFEAT*FW-1:0] feat_o,
   input  logic [CW-1:0]       class_i,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [CW-1:0]       m_class,
   output logic                busy
);

   localparam int IW = (NFEAT > 1) ? $clog2(NFEAT) : 1;
   localparam logic [IW-1:0] LAST = IW'(NFEAT - 1);
   localparam logic [7:0] SLAST = 8'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SETTLE,
      ST_OUT
   } state_t;

   state_t state, state_nx;

   logic [IW-1:0] idx;
   logic [7:0]    cnt;
   logic [FW-1:0] feat [NFEAT];
   logic [CW-1:0] cls;
   logic          acc;
   logic          take;
   logic          done;

   assign s_ready = (state == ST_LOAD);
   assign m_valid = (state == ST_OUT);
   assign busy    = (state != ST_LOAD);
   assign m_class = cls;

   assign acc  = s_valid && s_ready;
   assign take = m_valid && m_ready;
   assign done = (state == ST_SETTLE) && (cnt == SLAST);

   // Feature registers drive the tree directly, slot i at bits [i*FW +: FW].
   for (genvar g = 0; g < NFEAT; g++) begin : g_feat
      assign feat_o[g*FW +: FW] = feat[g];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_LOAD;
      else     state <= state_nx;
   end

   // Next state: flush overrides every handshake.
   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = ST_LOAD;
      end else begin
         unique case (state)
            ST_LOAD:   if (acc && idx == LAST) state_nx = ST_SETTLE;
            ST_SETTLE: if (done) state_nx = ST_OUT;
            ST_OUT:    if (take) state_nx = ST_LOAD;
            default:   state_nx = ST_LOAD;
         endcase
      end
   end

   // Datapath: slot writes, slot index, settle timer and class capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         cnt <= '0;
         cls <= '0;
         for (int i = 0; i < NFEAT; i++) feat[i] <= '0;
      end else if (flush) begin
         idx <= '0;
         cnt <= '0;
      end else begin
         if (acc) begin
            feat[idx] <= s_data;
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
         end
         if (state == ST_SETTLE) cnt <= done ? 8'd0 : cnt + 8'd1;
         if (done) cls <= class_i;
      end
   end

endmodule
